// File: rtl/mole_light_sequencer_if.sv
// Control/status bundle between the game-timing logic, the mole light
// sequencer and the board LED / score display.
interface mole_light_sequencer_if #(
  parameter int NUM_LIGHTS = 9,
  parameter int TIMER_W    = 28,
  parameter int LFSR_W     = 16,
  parameter int CNT_W      = 8
);
  localparam int IDX_W = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;

  logic                  start;
  logic                  load_seed;
  logic [LFSR_W-1:0]     seed;
  logic [TIMER_W-1:0]    on_time;
  logic [TIMER_W-1:0]    gap_time;
  logic [NUM_LIGHTS-1:0] hit_in;
  logic                  clear_stats;

  logic [NUM_LIGHTS-1:0] lights_out;
  logic [IDX_W-1:0]      active_idx;
  logic                  hit_pulse;
  logic                  miss_pulse;
  logic                  wrong_pulse;
  logic                  busy;
  logic [CNT_W-1:0]      hit_count;
  logic [CNT_W-1:0]      miss_count;
  logic [CNT_W-1:0]      wrong_count;

  modport master (
    output start, load_seed, seed, on_time, gap_time, hit_in, clear_stats,
    input  lights_out, active_idx, hit_pulse, miss_pulse, wrong_pulse, busy,
           hit_count, miss_count, wrong_count
  );

  modport slave (
    input  start, load_seed, seed, on_time, gap_time, hit_in, clear_stats,
    output lights_out, active_idx, hit_pulse, miss_pulse, wrong_pulse, busy,
           hit_count, miss_count, wrong_count
  );
endinterface

// File: rtl/mole_light_sequencer.sv
// Whack-a-mole light sequencer: LFSR-driven non-repeating single-light moles
// with programmable on/gap times and saturating hit/miss/wrong statistics.
module mole_light_sequencer #(
  parameter int                NUM_LIGHTS = 9,
  parameter int                TIMER_W    = 28,
  parameter int                LFSR_W     = 16,
  parameter logic [LFSR_W-1:0] LFSR_TAPS  = 16'hB400,
  parameter int                CNT_W      = 8
) (
  input  logic                   clk,
  input  logic                   reset,
  mole_light_sequencer_if.slave  bus
);
  localparam int               IDX_W  = (NUM_LIGHTS > 1) ? $clog2(NUM_LIGHTS) : 1;
  localparam logic [IDX_W:0]   NUM_L  = (IDX_W+1)'(NUM_LIGHTS);
  localparam bit               SINGLE = (NUM_LIGHTS == 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_GAP,
    S_PICK,
    S_ON
  } state_t;

  state_t                state_q, state_d;
  logic [LFSR_W-1:0]     lfsr_q, lfsr_d;
  logic [TIMER_W-1:0]    timer_q, timer_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [NUM_LIGHTS-1:0] lights_q, lights_d;
  logic                  hit_q, hit_d;
  logic                  miss_q, miss_d;
  logic                  wrong_q, wrong_d;
  logic                  busy_q, busy_d;
  logic [CNT_W-1:0]      hit_cnt_q, hit_cnt_d;
  logic [CNT_W-1:0]      miss_cnt_q, miss_cnt_d;
  logic [CNT_W-1:0]      wrong_cnt_q, wrong_cnt_d;

  logic [IDX_W-1:0]      cand;
  logic                  cand_ok;
  logic [NUM_LIGHTS-1:0] cand_onehot;
  logic                  press_match;
  logic                  press_other;
  logic                  inc_hit, inc_miss, inc_wrong;

  // LFSR free-runs in every state; a zero seed would lock it up, so it becomes 1.
  always_comb begin
    lfsr_d = lfsr_q >> 1;
    if (lfsr_q[0]) begin
      lfsr_d = (lfsr_q >> 1) ^ LFSR_TAPS;
    end
    if (bus.load_seed) begin
      lfsr_d = (bus.seed == '0) ? LFSR_W'(1) : bus.seed;
    end
  end

  always_comb begin
    cand    = lfsr_q[IDX_W-1:0];
    cand_ok = ({1'b0, cand} < NUM_L) && (SINGLE || (cand != idx_q));
    cand_onehot = '0;
    for (int unsigned i = 0; i < NUM_LIGHTS; i++) begin
      cand_onehot[i] = (cand == IDX_W'(i));
    end
  end

  // While ON, lights_q is exactly the one-hot of the active index, so it
  // doubles as the mask separating the correct press from wrong ones.
  always_comb begin
    press_match = |(bus.hit_in & lights_q);
    press_other = |(bus.hit_in & ~lights_q);
  end

  always_comb begin
    state_d   = state_q;
    timer_d   = timer_q;
    idx_d     = idx_q;
    lights_d  = lights_q;
    hit_d     = 1'b0;
    miss_d    = 1'b0;
    wrong_d   = 1'b0;
    inc_hit   = 1'b0;
    inc_miss  = 1'b0;
    inc_wrong = 1'b0;

    case (state_q)
      S_IDLE: begin
        lights_d = '0;
        if (bus.start) begin
          timer_d = bus.gap_time;
          state_d = S_GAP;
        end
      end
      S_GAP: begin
        if (timer_q == '0) begin
          state_d = S_PICK;
        end else begin
          timer_d = timer_q - TIMER_W'(1);
        end
      end
      S_PICK: begin
        if (cand_ok) begin
          lights_d = cand_onehot;
          idx_d    = cand;
          timer_d  = bus.on_time;
          state_d  = S_ON;
        end
      end
      S_ON: begin
        if (press_match) begin
          hit_d    = 1'b1;
          inc_hit  = 1'b1;
          lights_d = '0;
          timer_d  = bus.gap_time;
          state_d  = S_GAP;
        end else begin
          if (press_other) begin
            wrong_d   = 1'b1;
            inc_wrong = 1'b1;
          end
          if (timer_q == '0) begin
            miss_d   = 1'b1;
            inc_miss = 1'b1;
            lights_d = '0;
            timer_d  = bus.gap_time;
            state_d  = S_GAP;
          end else begin
            timer_d = timer_q - TIMER_W'(1);
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Dropping start aborts from any state without scoring the current mole.
    if (!bus.start) begin
      state_d   = S_IDLE;
      lights_d  = '0;
      timer_d   = timer_q;
      idx_d     = idx_q;
      hit_d     = 1'b0;
      miss_d    = 1'b0;
      wrong_d   = 1'b0;
      inc_hit   = 1'b0;
      inc_miss  = 1'b0;
      inc_wrong = 1'b0;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_comb begin
    hit_cnt_d   = hit_cnt_q;
    miss_cnt_d  = miss_cnt_q;
    wrong_cnt_d = wrong_cnt_q;
    if (bus.clear_stats) begin
      hit_cnt_d   = '0;
      miss_cnt_d  = '0;
      wrong_cnt_d = '0;
    end else begin
      if (inc_hit && (hit_cnt_q != '1)) begin
        hit_cnt_d = hit_cnt_q + CNT_W'(1);
      end
      if (inc_miss && (miss_cnt_q != '1)) begin
        miss_cnt_d = miss_cnt_q + CNT_W'(1);
      end
      if (inc_wrong && (wrong_cnt_q != '1)) begin
        wrong_cnt_d = wrong_cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= LFSR_W'(1);
      timer_q     <= '0;
      idx_q       <= '0;
      lights_q    <= '0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
      wrong_q     <= 1'b0;
      busy_q      <= 1'b0;
      hit_cnt_q   <= '0;
      miss_cnt_q  <= '0;
      wrong_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      timer_q     <= timer_d;
      idx_q       <= idx_d;
      lights_q    <= lights_d;
      hit_q       <= hit_d;
      miss_q      <= miss_d;
      wrong_q     <= wrong_d;
      busy_q      <= busy_d;
      hit_cnt_q   <= hit_cnt_d;
      miss_cnt_q  <= miss_cnt_d;
      wrong_cnt_q <= wrong_cnt_d;
    end
  end

  assign bus.lights_out  = lights_q;
  assign bus.active_idx  = idx_q;
  assign bus.hit_pulse   = hit_q;
  assign bus.miss_pulse  = miss_q;
  assign bus.wrong_pulse = wrong_q;
  assign bus.busy        = busy_q;
  assign bus.hit_count   = hit_cnt_q;
  assign bus.miss_count  = miss_cnt_q;
  assign bus.wrong_count = wrong_cnt_q;

endmodule

// File: tb/tb_mole_light_sequencer.sv
// Scoreboard bench for mole_light_sequencer: stimulus queues expected pulses,
// a monitor pops and compares them; LFSR reference predicts each mole index.
module tb_mole_light_sequencer;
  localparam int NL = 9;
  localparam int TW = 28;
  localparam int LW = 16;
  localparam int CW = 8;
  localparam int IW = 4;
  localparam logic [LW-1:0] TAPS = 16'hB400;

  localparam logic [2:0] K_HIT   = 3'b100;
  localparam logic [2:0] K_MISS  = 3'b010;
  localparam logic [2:0] K_WRONG = 3'b001;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  mole_light_sequencer_if #(.NUM_LIGHTS(NL), .TIMER_W(TW), .LFSR_W(LW), .CNT_W(CW)) bus ();
  mole_light_sequencer_if #(.NUM_LIGHTS(4),  .TIMER_W(TW), .LFSR_W(LW), .CNT_W(CW)) bus4 ();
  mole_light_sequencer_if #(.NUM_LIGHTS(1),  .TIMER_W(TW), .LFSR_W(LW), .CNT_W(CW)) bus1 ();

  mole_light_sequencer #(.NUM_LIGHTS(NL), .TIMER_W(TW), .LFSR_W(LW), .LFSR_TAPS(TAPS), .CNT_W(CW))
    dut (.clk(clk), .reset(reset), .bus(bus));
  mole_light_sequencer #(.NUM_LIGHTS(4), .TIMER_W(TW), .LFSR_W(LW), .LFSR_TAPS(TAPS), .CNT_W(CW))
    dut4 (.clk(clk), .reset(reset), .bus(bus4));
  mole_light_sequencer #(.NUM_LIGHTS(1), .TIMER_W(TW), .LFSR_W(LW), .LFSR_TAPS(TAPS), .CNT_W(CW))
    dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic [2:0]    kind;
    logic          lit;
    logic [CW-1:0] hc;
    logic [CW-1:0] mc;
    logic [CW-1:0] wc;
  } exp_t;
  exp_t exp_q[$];

  function automatic logic [LW-1:0] adv(input logic [LW-1:0] v);
    return v[0] ? ((v >> 1) ^ TAPS) : (v >> 1);
  endfunction

  // Reference LFSR following the documented update rule.
  logic [LW-1:0] m_lfsr;
  always @(posedge clk or negedge reset) begin
    if (!reset) m_lfsr <= LW'(1);
    else if (bus.load_seed) m_lfsr <= (bus.seed == '0) ? LW'(1) : bus.seed;
    else m_lfsr <= adv(m_lfsr);
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] kind, input logic lit, input int hc, input int mc, input int wc);
    exp_t e;
    e.kind = kind;
    e.lit  = lit;
    e.hc   = CW'(hc);
    e.mc   = CW'(mc);
    e.wc   = CW'(wc);
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lit(output int idx);
    logic was;
    int n;
    was = (bus.lights_out != '0);
    idx = 0;
    for (n = 0; n < 200; n++) begin
      tick();
      if (bus.lights_out != '0 && !was) break;
      was = (bus.lights_out != '0);
    end
    if (n == 200) begin
      checks++;
      failures++;
      $display("FAIL wait_lit: got no mole within 200 cycles expected a mole");
    end
    for (int i = 0; i < NL; i++) if (bus.lights_out[i]) idx = i;
  endtask

  task automatic check_counts(input string name, input int hc, input int mc, input int wc);
    check({name, "_hit_count"},   int'(bus.hit_count),   hc);
    check({name, "_miss_count"},  int'(bus.miss_count),  mc);
    check({name, "_wrong_count"}, int'(bus.wrong_count), wc);
  endtask

  // Monitor: scoreboard for pulses, plus reference check of every new mole.
  initial begin
    logic [LW-1:0] prev_lfsr;
    logic [NL-1:0] prev_lights;
    int last_idx;
    int idx;
    exp_t e;
    prev_lfsr = LW'(1);
    prev_lights = '0;
    last_idx = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        prev_lights = '0;
        last_idx = 0;
        prev_lfsr = m_lfsr;
        continue;
      end
      if ({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse} != 3'b000) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_pulse: got hit/miss/wrong=%b expected none",
                   {bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse});
        end else begin
          e = exp_q.pop_front();
          check("pulse_kind", int'({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse}), int'(e.kind));
          check("pulse_lit", int'(bus.lights_out != '0), int'(e.lit));
          check("pulse_hit_count", int'(bus.hit_count), int'(e.hc));
          check("pulse_miss_count", int'(bus.miss_count), int'(e.mc));
          check("pulse_wrong_count", int'(bus.wrong_count), int'(e.wc));
        end
      end
      if (bus.lights_out != '0 && prev_lights == '0) begin
        idx = int'(bus.active_idx);
        check("mole_idx_model", idx, int'(prev_lfsr[IW-1:0]));
        check("mole_onehot", int'(bus.lights_out), 1 << int'(prev_lfsr[IW-1:0]));
        check("mole_valid_norepeat", int'(idx < NL && idx != last_idx), 1);
        last_idx = idx;
      end
      prev_lights = bus.lights_out;
      prev_lfsr = m_lfsr;
    end
  end

  // Property monitors for the 4-light and 1-light builds.
  int n4 = 0;
  int n1 = 0;
  initial begin
    logic [3:0] p4;
    logic p1;
    int last4;
    p4 = '0;
    p1 = 1'b0;
    last4 = 0;
    forever begin
      @(negedge clk);
      if (!reset) begin
        p4 = '0;
        p1 = 1'b0;
        last4 = 0;
        continue;
      end
      if (bus4.lights_out != '0 && p4 == '0) begin
        n4++;
        check("n4_onehot", int'(bus4.lights_out), 1 << int'(bus4.active_idx));
        check("n4_norepeat", int'(int'(bus4.active_idx) != last4), 1);
        last4 = int'(bus4.active_idx);
      end
      if (bus1.lights_out != '0 && !p1) begin
        n1++;
        check("n1_idx", int'(bus1.active_idx), 0);
      end
      p4 = bus4.lights_out;
      p1 = bus1.lights_out;
    end
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int dark;
    int lit;
    int p;
    logic [LW-1:0] v;

    bus.start = 1'b0;  bus.load_seed = 1'b0; bus.seed = '0;
    bus.on_time = TW'(5); bus.gap_time = TW'(3);
    bus.hit_in = '0;   bus.clear_stats = 1'b0;
    bus4.start = 1'b1; bus4.load_seed = 1'b0; bus4.seed = '0;
    bus4.on_time = TW'(1); bus4.gap_time = TW'(1);
    bus4.hit_in = '0;  bus4.clear_stats = 1'b0;
    bus1.start = 1'b1; bus1.load_seed = 1'b0; bus1.seed = '0;
    bus1.on_time = TW'(1); bus1.gap_time = TW'(1);
    bus1.hit_in = '0;  bus1.clear_stats = 1'b0;

    repeat (3) tick();
    check("rst_lights", int'(bus.lights_out), 0);
    check("rst_busy", int'(bus.busy), 0);
    check("rst_idx", int'(bus.active_idx), 0);
    check("rst_pulses", int'({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse}), 0);
    check_counts("rst", 0, 0, 0);
    reset = 1'b1;
    tick();
    check("idle_busy", int'(bus.busy), 0);

    // Mole 1: gap of 4 cycles, pick cycles predicted by the reference LFSR, 6 lit cycles.
    bus.start = 1'b1;
    tick();
    check("start_busy", int'(bus.busy), 1);
    check("start_dark", int'(bus.lights_out), 0);
    v = m_lfsr;
    repeat (4) v = adv(v);
    p = 1;
    while (!(int'(v[IW-1:0]) < NL && v[IW-1:0] != '0)) begin
      v = adv(v);
      p++;
    end
    dark = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.lights_out != '0) break;
      dark++;
    end
    check("first_dark_cycles", dark, 4 + p);
    push_exp(K_MISS, 1'b0, 0, 1, 0);
    lit = 1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.lights_out == '0) break;
      lit++;
    end
    check("first_lit_cycles", lit, 6);

    for (int m = 2; m <= 50; m++) begin
      wait_lit(k);
      push_exp(K_MISS, 1'b0, 0, m, 0);
    end

    // Hit on the 2nd lit cycle.
    wait_lit(k);
    tick();
    bus.hit_in = NL'(1) << k;
    push_exp(K_HIT, 1'b0, 1, 50, 0);
    tick();
    bus.hit_in = '0;
    check("after_hit_busy", int'(bus.busy), 1);
    check("after_hit_dark", int'(bus.lights_out), 0);

    // Wrong press keeps the mole lit; correct plus stray press is a clean hit.
    wait_lit(k);
    tick();
    bus.hit_in = NL'(1) << ((k + 1) % NL);
    push_exp(K_WRONG, 1'b1, 1, 50, 1);
    tick();
    bus.hit_in = (NL'(1) << k) | (NL'(1) << ((k + 2) % NL));
    push_exp(K_HIT, 1'b0, 2, 50, 1);
    tick();
    bus.hit_in = '0;

    // Hit on the final lit cycle.
    wait_lit(k);
    repeat (5) tick();
    check("final_cycle_still_lit", int'(bus.lights_out), 1 << k);
    bus.hit_in = NL'(1) << k;
    push_exp(K_HIT, 1'b0, 3, 50, 1);
    tick();
    bus.hit_in = '0;

    // Abort mid-mole, then presses in IDLE are ignored.
    wait_lit(k);
    tick();
    bus.start = 1'b0;
    tick();
    check("abort_dark", int'(bus.lights_out), 0);
    check("abort_busy", int'(bus.busy), 0);
    check("abort_idx", int'(bus.active_idx), k);
    check_counts("abort", 3, 50, 1);
    bus.hit_in = '1;
    repeat (3) tick();
    bus.hit_in = '0;
    tick();
    check_counts("idle_press", 3, 50, 1);

    // Zero seed, presses during GAP, then drive hit_count into saturation.
    bus.seed = '0;
    bus.load_seed = 1'b1;
    tick();
    bus.load_seed = 1'b0;
    bus.gap_time = TW'(0);
    bus.on_time = TW'(3);
    bus.start = 1'b1;
    tick();
    bus.hit_in = '1;
    tick();
    bus.hit_in = '0;
    for (int n = 4; n <= 256; n++) begin
      wait_lit(k);
      bus.hit_in = NL'(1) << k;
      push_exp(K_HIT, 1'b0, (n > 255) ? 255 : n, 50, 1);
      tick();
      bus.hit_in = '0;
    end

    // Clear wins over a simultaneous hit.
    wait_lit(k);
    bus.hit_in = NL'(1) << k;
    bus.clear_stats = 1'b1;
    push_exp(K_HIT, 1'b0, 0, 0, 0);
    tick();
    bus.hit_in = '0;
    bus.clear_stats = 1'b0;

    // Asynchronous reset mid-mole.
    wait_lit(k);
    #2;
    reset = 1'b0;
    #1;
    check("async_rst_lights", int'(bus.lights_out), 0);
    check("async_rst_busy", int'(bus.busy), 0);
    check("async_rst_idx", int'(bus.active_idx), 0);
    check("async_rst_pulses", int'({bus.hit_pulse, bus.miss_pulse, bus.wrong_pulse}), 0);
    check_counts("async_rst", 0, 0, 0);
    bus.start = 1'b0;
    tick();
    reset = 1'b1;
    repeat (4) tick();
    check("idle_after_rst_busy", int'(bus.busy), 0);

    check("scoreboard_drained", exp_q.size(), 0);
    check("n4_moles_seen", int'(n4 > 0), 1);
    check("n1_moles_seen", int'(n1 > 0), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
